// File: rtl/sata_fis_demux_n.sv
// N-way frame-locked SATA FIS demultiplexer with a 2-entry registered input buffer.
// Define SATA_FIS_DEMUX_STAT_EN to add per-channel frame and drop statistics counters.
module sata_fis_demux_n #(
    parameter int DWIDTH    = 32,
    parameter int CHANNELS  = 2,
    parameter int CNTWIDTH  = 16,
    localparam int SELWIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         reset,
    input  logic                         clk,
    input  logic [SELWIDTH-1:0]          i_sel,
    input  logic [DWIDTH-1:0]            i_dat,
    input  logic                         i_val,
    input  logic                         i_eop,
    input  logic                         i_err,
    output logic                         i_rdy,
    output logic [CHANNELS*DWIDTH-1:0]   o_dat,
    output logic [CHANNELS-1:0]          o_val,
    output logic [CHANNELS-1:0]          o_eop,
    output logic [CHANNELS-1:0]          o_err,
    input  logic [CHANNELS-1:0]          o_rdy,
    output logic                         drop
`ifdef SATA_FIS_DEMUX_STAT_EN
    ,
    input  logic                         stat_clr,
    output logic [CHANNELS*CNTWIDTH-1:0] stat_frm,
    output logic [CNTWIDTH-1:0]          stat_drop
`endif
);

    logic [DWIDTH-1:0]   dat_q [2];
    logic [SELWIDTH-1:0] tag_q [2];
    logic [1:0]          eop_q;
    logic [1:0]          err_q;
    logic                wr_ptr_q;
    logic                rd_ptr_q;
    logic [1:0]          cnt_q;
    logic [1:0]          cnt_d;
    logic                rdy_q;
    logic                sop_q;
    logic [SELWIDTH-1:0] sel_q;

    logic                push;
    logic                pop;
    logic [SELWIDTH-1:0] in_tag;
    logic                head_vld;
    logic                head_eop;
    logic                head_err;
    logic                head_in_range;
    logic [SELWIDTH-1:0] head_tag;
    logic [DWIDTH-1:0]   head_dat;
    logic [CHANNELS-1:0] hit;

    // The channel is latched on the first word only, so a frame never splits across channels.
    assign push     = i_val & rdy_q;
    assign in_tag   = sop_q ? i_sel : sel_q;
    assign i_rdy    = rdy_q;

    assign head_vld      = (cnt_q != 2'd0);
    assign head_dat      = dat_q[rd_ptr_q];
    assign head_tag      = tag_q[rd_ptr_q];
    assign head_eop      = eop_q[rd_ptr_q];
    assign head_err      = err_q[rd_ptr_q];
    assign head_in_range = ({1'b0, head_tag} < (SELWIDTH+1)'(CHANNELS));

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        assign hit[gi]                    = head_vld & (head_tag == SELWIDTH'(gi));
        assign o_dat[gi*DWIDTH +: DWIDTH] = head_dat;
    end

    assign o_val = hit;
    assign o_eop = hit & {CHANNELS{head_eop}};
    assign o_err = hit & {CHANNELS{head_err}};

    // Words for a missing channel drain without waiting on any consumer.
    assign pop  = head_vld & (~head_in_range | (|(hit & o_rdy)));
    assign drop = head_vld & ~head_in_range & head_eop;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= 2'd0;
            rdy_q    <= 1'b1;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            sop_q    <= 1'b1;
            sel_q    <= '0;
            eop_q    <= '0;
            err_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                dat_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            rdy_q <= (cnt_d != 2'd2);
            if (push) begin
                dat_q[wr_ptr_q] <= i_dat;
                tag_q[wr_ptr_q] <= in_tag;
                eop_q[wr_ptr_q] <= i_eop;
                err_q[wr_ptr_q] <= i_err;
                wr_ptr_q        <= ~wr_ptr_q;
                sop_q           <= i_eop;
                if (sop_q) begin
                    sel_q <= i_sel;
                end
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

`ifdef SATA_FIS_DEMUX_STAT_EN
    logic [CNTWIDTH-1:0] drop_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (stat_clr) begin
            drop_cnt_q <= '0;
        end else if (drop) begin
            drop_cnt_q <= drop_cnt_q + CNTWIDTH'(1);
        end
    end

    assign stat_drop = drop_cnt_q;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_stat
        logic [CNTWIDTH-1:0] frm_cnt_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                frm_cnt_q <= '0;
            end else if (stat_clr) begin
                frm_cnt_q <= '0;
            end else if (pop && hit[gi] && head_eop) begin
                frm_cnt_q <= frm_cnt_q + CNTWIDTH'(1);
            end
        end

        assign stat_frm[gi*CNTWIDTH +: CNTWIDTH] = frm_cnt_q;
    end
`endif

endmodule
